ps2_receiver: RTL and testbench
===============================

// Module: ps2_receiver
// PURPOSE
//  Receives device-to-host PS/2 frames on the raw keyboard clock/data pins and turns them
//  into scancode events on a strobe/pressed/code bus. This is the bus the ZX keyboard
//  matrix consumes. Handles E0 (extended) and F0 (break) prefixes, parity and stop-bit
//  checks, glitch filtering and frame timeout. Sits between the PS/2 pins and the keyboard matrix.
// PARAMETERS
//  FILTER_LEN  8      consecutive identical samples required before filtered ps2Ck changes (2..15)
//  TIMEOUT     56000  clock cycles without a falling edge before a partial frame is dropped (<65536)
// PORTS
//  clock     in   1  system clock; single clock domain
//  reset     in   1  asynchronous, active-low reset
//  ps2Ck     in   1  raw PS/2 clock pin (asynchronous)
//  ps2D      in   1  raw PS/2 data pin (asynchronous)
//  strobe    out  1  one-cycle pulse: code/pressed/extended hold a new key event
//  pressed   out  1  0 = make (key down), 1 = break (key up); matches matrix active-low
//  code      out  8  scancode byte, without prefixes
//  extended  out  1  1 = event was preceded by E0
//  error     out  1  one-cycle pulse on parity or stop-bit failure
// BEHAVIOUR
//  Reset (reset=0, async): strobe=0, error=0, code=8'h00, pressed=1, extended=0.
//   Also clears the FSM to IDLE, bit counter, shift register, the ext/brk prefix flags,
//   the timeout counter, and the filters (filtered ps2Ck=1).
//  Input conditioning:
//   - 2-FF synchronizer on both pins.
//   - ps2Ck filter: the filtered level toggles only after FILTER_LEN consecutive samples
//     disagree with it.
//   - Any shorter pulse is ignored.
//   - Bit event = filtered ps2Ck 1->0. Synchronized ps2D is sampled in that same cycle.
//  FSM:
//   - IDLE: on a bit event with data=0 (start), go to RECV with cnt=0. Data=1 is ignored.
//   - RECV: each bit event shifts data in LSB first. Events 0..7 are data, event 8 is parity.
//     After the parity bit, go to STOP.
//   - STOP: on the next bit event, check stop bit=1 and odd parity over data+parity.
//     Pass -> decode the byte, then IDLE. Fail -> error=1 for 1 cycle, clear ext/brk, then IDLE.
//  Timeout:
//   - The counter runs in RECV and STOP, reloads on every bit event, and is held at 0 in IDLE.
//   - On reaching TIMEOUT: go to IDLE, discard the partial byte, clear ext/brk.
//   - No strobe, no error.
//  Decode (good byte B):
//   - E0: ext=1, no strobe.
//   - F0: brk=1, no strobe.
//   - 00, AA, EE, FA, FC, FD, FE, FF (status/ACK/BAT): discarded, ext/brk cleared, no strobe.
//   - Any other byte: next cycle strobe=1 for exactly 1 cycle, code=B, pressed=brk,
//     extended=ext; then ext/brk are cleared.
//  Latency: strobe/error assert in the cycle after the cycle in which the stop-bit event
//   is detected.
//  Output holding: code/pressed/extended change only together with strobe and hold until the next strobe.
//  Boundaries:
//   - E0 F0 and F0 E0 both give ext=brk=1.
//   - A repeated prefix is idempotent.
//   - Back-to-back frames need no idle gap beyond the stop bit.
//   - Reset mid-frame drops the frame silently.
// TESTING
//  1 Frame 1C (start 0, bits 0011 1000, parity 0, stop 1) -> one strobe, code=1C, pressed=0,
//    extended=0, error never 1.
//  2 Frames F0,1C -> no strobe after F0; one strobe after 1C with code=1C, pressed=1, extended=0.
//  3 Frames E0,F0,75 -> single strobe, code=75, pressed=1, extended=1.
//  4 Frame 1C with parity bit flipped -> error pulse, no strobe. Then F0 (good) and 1C with
//    bad stop -> error. Then good 1C -> pressed=0, because the prefix was cleared.
//  5 ps2Ck low glitch of FILTER_LEN-2 cycles mid-frame -> no extra bit. Then 5 bits, idle for
//    TIMEOUT+10 cycles, then good frame 29 -> one strobe, code=29, no error.
//  6 Assert reset during bit 4 of a frame -> all outputs at reset values; a following AA frame
//    gives no strobe; the next 5A frame gives strobe, code=5A, pressed=0.

Source files
------------

// File: rtl/ps2_receiver.sv
// ---------------------------------------------------------------------------
// ps2_receiver
//
// Receives device-to-host PS/2 frames from the raw keyboard clock/data pins
// and turns them into scancode events for the ZX keyboard matrix.
// Handles E0 (extended) and F0 (break) prefixes. Checks parity and the stop
// bit. Filters glitches on the PS/2 clock. Drops partial frames after an
// idle timeout.
//
// Parameters
//   FILTER_LEN  consecutive disagreeing samples before filtered ps2Ck toggles (2..15)
//   TIMEOUT     idle cycles in a partial frame before it is dropped (<65536)
//
// Ports
//   clock     in   system clock, single domain
//   reset     in   asynchronous active-low reset
//   ps2Ck     in   raw PS/2 clock pin (asynchronous)
//   ps2D      in   raw PS/2 data pin (asynchronous)
//   strobe    out  one-cycle pulse, code/pressed/extended hold a new event
//   pressed   out  0 = make, 1 = break (active-low, as the matrix expects)
//   code      out  scancode byte without prefixes
//   extended  out  1 = event was preceded by E0
//   error     out  one-cycle pulse on parity or stop-bit failure
// ---------------------------------------------------------------------------
module ps2_receiver #(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 56000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ps2Ck,
   input  logic       ps2D,
   output logic       strobe,
   output logic       pressed,
   output logic [7:0] code,
   output logic       extended,
   output logic       error
);

   typedef enum logic [1:0] {IDLE, RECV, STOP} state_t;

   localparam logic [3:0]  FLT_LAST = 4'(FILTER_LEN - 1);
   localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

   // ------------------------------------------------------------------
   // Input conditioning
   // ------------------------------------------------------------------
   logic [1:0] ck_sync, d_sync;
   logic       ck_s, d_s;
   logic       ck_filt, ck_filt_q;
   logic [3:0] flt_cnt;
   logic       bit_event;

   // NOTE: every clocked process uses non-blocking assignments, so each
   // register samples the pre-edge value of the others (this is what makes
   // the synchronizer chain actually two stages deep).
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ck_sync <= 2'b11;
         d_sync  <= 2'b11;
      end else begin
         ck_sync <= {ck_sync[0], ps2Ck};
         d_sync  <= {d_sync[0], ps2D};
      end
   end

   assign ck_s = ck_sync[1];
   assign d_s  = d_sync[1];

   // The filtered level flips on the FILTER_LEN-th consecutive sample
   // that disagrees with it; any agreeing sample restarts the count.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ck_filt   <= 1'b1;
         ck_filt_q <= 1'b1;
         flt_cnt   <= '0;
      end else begin
         ck_filt_q <= ck_filt;
         if (ck_s != ck_filt) begin
            if (flt_cnt == FLT_LAST) begin
               ck_filt <= ck_s;
               flt_cnt <= '0;
            end else begin
               flt_cnt <= flt_cnt + 4'd1;
            end
         end else begin
            flt_cnt <= '0;
         end
      end
   end

   // One-cycle pulse on the filtered falling edge; d_s is sampled in the same cycle.
   assign bit_event = ck_filt_q & ~ck_filt;

   // ------------------------------------------------------------------
   // Frame FSM
   // ------------------------------------------------------------------
   state_t      state, state_next;
   logic [3:0]  bit_cnt;
   logic [8:0]  shreg;      // [7:0] data, [8] parity after nine shifts
   logic [15:0] tcnt;
   logic        ext_flag, brk_flag;
   logic        timed_out, frame_done, frame_ok;
   logic [7:0]  rx_byte;

   assign rx_byte = shreg[7:0];

   function automatic logic is_status(input logic [7:0] b);
      case (b)
         8'h00, 8'hAA, 8'hEE, 8'hFA,
         8'hFC, 8'hFD, 8'hFE, 8'hFF: is_status = 1'b1;
         default:                    is_status = 1'b0;
      endcase
   endfunction

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // NOTE: every output of this block gets a default first, so no path
   // can leave one unassigned and infer a latch.
   always_comb begin
      state_next = state;
      timed_out  = 1'b0;
      frame_done = 1'b0;
      frame_ok   = 1'b0;
      case (state)
         IDLE: begin
            if (bit_event && !d_s) state_next = RECV;
         end
         RECV: begin
            if (bit_event) begin
               if (bit_cnt == 4'd8) state_next = STOP;
            end else if (tcnt == TO_LIMIT) begin
               timed_out  = 1'b1;
               state_next = IDLE;
            end
         end
         STOP: begin
            if (bit_event) begin
               frame_done = 1'b1;
               // Odd parity: data plus parity bit must hold an odd number of ones.
               frame_ok   = d_s && (^shreg);
               state_next = IDLE;
            end else if (tcnt == TO_LIMIT) begin
               timed_out  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath: shift register, timeout counter, prefix flags and outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         bit_cnt  <= '0;
         shreg    <= '0;
         tcnt     <= '0;
         ext_flag <= 1'b0;
         brk_flag <= 1'b0;
         strobe   <= 1'b0;
         error    <= 1'b0;
         code     <= 8'h00;
         pressed  <= 1'b1;
         extended <= 1'b0;
      end else begin
         strobe <= 1'b0;
         error  <= 1'b0;

         // Held at zero in IDLE; restarts on every bit event while in a frame.
         if (state_next == IDLE || bit_event) tcnt <= '0;
         else                                 tcnt <= tcnt + 16'd1;

         if (state == IDLE && bit_event && !d_s) begin
            bit_cnt <= '0;
            shreg   <= '0;
         end else if (state == RECV && bit_event) begin
            shreg   <= {d_s, shreg[8:1]};
            bit_cnt <= bit_cnt + 4'd1;
         end

         if (timed_out) begin
            shreg    <= '0;
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
         end

         if (frame_done) begin
            if (!frame_ok) begin
               error    <= 1'b1;
               ext_flag <= 1'b0;
               brk_flag <= 1'b0;
            end else if (rx_byte == 8'hE0) begin
               ext_flag <= 1'b1;
            end else if (rx_byte == 8'hF0) begin
               brk_flag <= 1'b1;
            end else if (is_status(rx_byte)) begin
               ext_flag <= 1'b0;
               brk_flag <= 1'b0;
            end else begin
               strobe   <= 1'b1;
               code     <= rx_byte;
               pressed  <= brk_flag;
               extended <= ext_flag;
               ext_flag <= 1'b0;
               brk_flag <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_receiver.sv
// ---------------------------------------------------------------------------
// tb_ps2_receiver
//
// Directed bench for ps2_receiver. The bench drives PS/2 frames bit by bit.
// A monitor counts strobe and error pulses and latches the event fields on
// each strobe. Each checkpoint compares against hand-computed values.
// ---------------------------------------------------------------------------
module tb_ps2_receiver;

   localparam int FL = 8;
   localparam int TO = 2000;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       ps2Ck = 1'b1;
   logic       ps2D  = 1'b1;
   logic       strobe, pressed, extended, error;
   logic [7:0] code;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   int         n_strobe = 0;
   int         n_err    = 0;
   logic [7:0] last_code;
   logic       last_pressed, last_ext;
   int         s0, e0;

   always #5 clock = ~clock;

   ps2_receiver #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
      .clock    (clock),
      .reset    (reset),
      .ps2Ck    (ps2Ck),
      .ps2D     (ps2D),
      .strobe   (strobe),
      .pressed  (pressed),
      .code     (code),
      .extended (extended),
      .error    (error)
   );

   // Sample away from the active edge.
   always @(negedge clock) begin
      if (strobe) begin
         n_strobe     <= n_strobe + 1;
         last_code    <= code;
         last_pressed <= pressed;
         last_ext     <= extended;
      end
      if (error) n_err <= n_err + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   // One PS/2 bit: data set up during the high phase, then a 20-cycle low pulse.
   task automatic send_bit(input logic b);
      @(negedge clock);
      ps2D = b;
      wait_cycles(10);
      ps2Ck = 1'b0;
      wait_cycles(20);
      ps2Ck = 1'b1;
      wait_cycles(9);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit((~^b) ^ bad_par);
      send_bit(~bad_stop);
      ps2D = 1'b1;
   endtask

   task automatic mark();
      wait_cycles(2);
      s0 = n_strobe;
      e0 = n_err;
   endtask

   initial begin
      logic [7:0] b;

      // Reset state
      wait_cycles(3);
      check("rst strobe",   strobe,   1'b0);
      check("rst error",    error,    1'b0);
      check("rst code",     code,     8'h00);
      check("rst pressed",  pressed,  1'b1);
      check("rst extended", extended, 1'b0);
      reset = 1'b1;
      wait_cycles(5);

      // 1: make 1C
      mark();
      send_frame(8'h1C, 1'b0, 1'b0);
      wait_cycles(20);
      check("t1 strobes",  n_strobe - s0, 1);
      check("t1 code",     last_code,     8'h1C);
      check("t1 pressed",  last_pressed,  1'b0);
      check("t1 extended", last_ext,      1'b0);
      check("t1 errors",   n_err - e0,    0);
      check("t1 hold code", code,         8'h1C);

      // 2: F0 1C -> break
      mark();
      send_frame(8'hF0, 1'b0, 1'b0);
      wait_cycles(20);
      check("t2 no strobe after F0", n_strobe - s0, 0);
      send_frame(8'h1C, 1'b0, 1'b0);
      wait_cycles(20);
      check("t2 strobes",  n_strobe - s0, 1);
      check("t2 code",     last_code,     8'h1C);
      check("t2 pressed",  last_pressed,  1'b1);
      check("t2 extended", last_ext,      1'b0);

      // 3: E0 F0 75 -> extended break
      mark();
      send_frame(8'hE0, 1'b0, 1'b0);
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h75, 1'b0, 1'b0);
      wait_cycles(20);
      check("t3 strobes",  n_strobe - s0, 1);
      check("t3 code",     last_code,     8'h75);
      check("t3 pressed",  last_pressed,  1'b1);
      check("t3 extended", last_ext,      1'b1);

      // F0 E0 E0 6B: reversed order and repeated prefix
      mark();
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'hE0, 1'b0, 1'b0);
      send_frame(8'hE0, 1'b0, 1'b0);
      send_frame(8'h6B, 1'b0, 1'b0);
      wait_cycles(20);
      check("t3b strobes",  n_strobe - s0, 1);
      check("t3b code",     last_code,     8'h6B);
      check("t3b pressed",  last_pressed,  1'b1);
      check("t3b extended", last_ext,      1'b1);

      // 4: bad parity, then F0 + bad stop, then good 1C
      mark();
      send_frame(8'h1C, 1'b1, 1'b0);
      wait_cycles(20);
      check("t4 parity error", n_err - e0,    1);
      check("t4 parity nostb", n_strobe - s0, 0);
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b1);
      wait_cycles(20);
      check("t4 stop error",   n_err - e0,    2);
      check("t4 stop nostb",   n_strobe - s0, 0);
      send_frame(8'h1C, 1'b0, 1'b0);
      wait_cycles(20);
      check("t4 strobes", n_strobe - s0, 1);
      check("t4 code",    last_code,     8'h1C);
      check("t4 pressed", last_pressed,  1'b0);

      // 5: short glitch mid-frame, then timeout on a partial frame
      mark();
      b = 8'h16;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) begin
         send_bit(b[i]);
         if (i == 2) begin
            ps2Ck = 1'b0;
            wait_cycles(FL - 2);
            ps2Ck = 1'b1;
            wait_cycles(10);
         end
      end
      send_bit(~^b);
      send_bit(1'b1);
      wait_cycles(20);
      check("t5 glitch strobes", n_strobe - s0, 1);
      check("t5 glitch code",    last_code,     8'h16);
      check("t5 glitch errors",  n_err - e0,    0);
      mark();
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      wait_cycles(TO + 10);
      check("t5 timeout strobes", n_strobe - s0, 0);
      check("t5 timeout errors",  n_err - e0,    0);
      send_frame(8'h29, 1'b0, 1'b0);
      wait_cycles(20);
      check("t5 strobes", n_strobe - s0, 1);
      check("t5 code",    last_code,     8'h29);
      check("t5 errors",  n_err - e0,    0);

      // 6: reset during bit 4
      mark();
      b = 8'h5A;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(b[i]);
      @(negedge clock);
      ps2D = b[4];
      wait_cycles(10);
      ps2Ck = 1'b0;
      wait_cycles(5);
      reset = 1'b0;
      wait_cycles(2);
      ps2Ck = 1'b1;
      ps2D  = 1'b1;
      wait_cycles(20);
      check("t6 rst strobe",   strobe,   1'b0);
      check("t6 rst error",    error,    1'b0);
      check("t6 rst code",     code,     8'h00);
      check("t6 rst pressed",  pressed,  1'b1);
      check("t6 rst extended", extended, 1'b0);
      reset = 1'b1;
      wait_cycles(10);
      send_frame(8'hAA, 1'b0, 1'b0);
      wait_cycles(20);
      check("t6 AA nostb", n_strobe - s0, 0);
      send_frame(8'h5A, 1'b0, 1'b0);
      wait_cycles(20);
      check("t6 strobes", n_strobe - s0, 1);
      check("t6 code",    last_code,     8'h5A);
      check("t6 pressed", last_pressed,  1'b0);
      check("t6 errors",  n_err - e0,    0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
